// File: rtl/branch_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// branch_recovery_ctrl
// Sequences misprediction recovery for resolved control-transfer ops coming
// from the execute-stage control ALU. The block captures the oldest
// mispredicted branch (next PC, checkpoint ID and age). It holds a pipeline
// flush, requests a rename-map checkpoint restore, and then issues a single
// fetch redirect.
//
// Optional build macro: RECOVERY_STATS_EN
//   When defined, adds the mispredCnt_o and recoveryCyc_o statistics outputs.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   exeValid_i        control-ALU result valid this cycle
//   exeMispredict_i   mispredict flag of that result
//   exeNextPC_i       resolved next PC
//   exeAge_i          branch age relative to the ROB head (smaller = older)
//   exeBID_i          checkpoint ID of the resolving branch
//   commitCnt_i       instructions retired this cycle (0..3)
//   restoreAck_i      rename has restored the checkpoint
//   flush_o           squash ops younger than the captured branch
//   flushAge_o        captured age (flush boundary), commit-adjusted
//   restoreReq_o      checkpoint restore request
//   restoreBID_o      checkpoint to restore
//   redirect_o        one-cycle fetch redirect strobe
//   redirectPC_o      redirect target
//   issueStall_o      freeze issue while a recovery is in progress
//   mispredCnt_o      (stats) accepted captures, including replacements
//   recoveryCyc_o     (stats) cycles spent outside IDLE
// ---------------------------------------------------------------------------
module branch_recovery_ctrl #(
    parameter int unsigned SIZE_PC      = 32,
    parameter int unsigned AGE_W        = 7,
    parameter int unsigned BID_W        = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exeValid_i,
    input  logic               exeMispredict_i,
    input  logic [SIZE_PC-1:0] exeNextPC_i,
    input  logic [AGE_W-1:0]   exeAge_i,
    input  logic [BID_W-1:0]   exeBID_i,
    input  logic [1:0]         commitCnt_i,
    input  logic               restoreAck_i,
    output logic               flush_o,
    output logic [AGE_W-1:0]   flushAge_o,
    output logic               restoreReq_o,
    output logic [BID_W-1:0]   restoreBID_o,
    output logic               redirect_o,
    output logic [SIZE_PC-1:0] redirectPC_o,
    output logic               issueStall_o
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0]        mispredCnt_o,
    output logic [31:0]        recoveryCyc_o
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_RESTORE  = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam int unsigned     CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [AGE_W-1:0]   age_nxt;
    logic [SIZE_PC-1:0] pc_nxt;
    logic [BID_W-1:0]   bid_nxt;

    logic               event_c;
    logic [AGE_W-1:0]   age_adj;
    logic               older_c;
    logic               capture_c;

    // Stored age moves toward the ROB head as instructions retire (saturating).
    assign event_c   = exeValid_i & exeMispredict_i;
    assign age_adj   = (flushAge_o > AGE_W'(commitCnt_i)) ? (flushAge_o - AGE_W'(commitCnt_i))
                                                           : '0;
    assign older_c   = event_c & (exeAge_i < age_adj);
    assign capture_c = (state == S_IDLE) ? event_c : older_c;

    // Next-state and captured-value logic; an older branch preempts any phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        age_nxt   = age_adj;
        pc_nxt    = redirectPC_o;
        bid_nxt   = restoreBID_o;
        if (capture_c) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = '0;
            age_nxt   = exeAge_i;
            pc_nxt    = exeNextPC_i;
            bid_nxt   = exeBID_i;
        end else begin
            case (state)
                S_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state_nxt = S_RESTORE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_RESTORE: begin
                    if (restoreAck_i) begin
                        state_nxt = S_REDIRECT;
                    end
                end
                S_REDIRECT: state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // State, captured values and registered phase outputs.
    // A redirect strobe already on the bus cannot be retracted; an older
    // branch seen during REDIRECT sends the FSM back to FLUSH, and that
    // flush squashes the stale fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            flushAge_o   <= '0;
            redirectPC_o <= '0;
            restoreBID_o <= '0;
            flush_o      <= 1'b0;
            restoreReq_o <= 1'b0;
            redirect_o   <= 1'b0;
            issueStall_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            flushAge_o   <= age_nxt;
            redirectPC_o <= pc_nxt;
            restoreBID_o <= bid_nxt;
            flush_o      <= (state_nxt == S_FLUSH);
            restoreReq_o <= (state_nxt == S_RESTORE);
            redirect_o   <= (state_nxt == S_REDIRECT);
            issueStall_o <= (state_nxt != S_IDLE);
        end
    end

`ifdef RECOVERY_STATS_EN
    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredCnt_o  <= '0;
            recoveryCyc_o <= '0;
        end else begin
            if (capture_c) begin
                mispredCnt_o <= mispredCnt_o + 32'd1;
            end
            if (state != S_IDLE) begin
                recoveryCyc_o <= recoveryCyc_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_recovery_ctrl
// Bench for branch_recovery_ctrl. It runs directed recovery scenarios and a
// long randomized run. A recovery reference model checks every cycle. The
// model holds the remaining flush cycles, an awaiting-ack flag and a pending
// redirect flag. The optional statistics outputs are checked when
// RECOVERY_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_recovery_ctrl;

    localparam int unsigned SIZE_PC = 32;
    localparam int unsigned AGE_W   = 7;
    localparam int unsigned BID_W   = 3;
    localparam int unsigned FC      = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               exeValid_i = 1'b0;
    logic               exeMispredict_i = 1'b0;
    logic [SIZE_PC-1:0] exeNextPC_i = '0;
    logic [AGE_W-1:0]   exeAge_i = '0;
    logic [BID_W-1:0]   exeBID_i = '0;
    logic [1:0]         commitCnt_i = '0;
    logic               restoreAck_i = 1'b0;
    logic               flush_o;
    logic [AGE_W-1:0]   flushAge_o;
    logic               restoreReq_o;
    logic [BID_W-1:0]   restoreBID_o;
    logic               redirect_o;
    logic [SIZE_PC-1:0] redirectPC_o;
    logic               issueStall_o;
`ifdef RECOVERY_STATS_EN
    logic [31:0]        mispredCnt_o;
    logic [31:0]        recoveryCyc_o;
`endif

    always #5 clk = ~clk;

    branch_recovery_ctrl #(
        .SIZE_PC(SIZE_PC), .AGE_W(AGE_W), .BID_W(BID_W), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .reset(reset),
        .exeValid_i(exeValid_i), .exeMispredict_i(exeMispredict_i),
        .exeNextPC_i(exeNextPC_i), .exeAge_i(exeAge_i), .exeBID_i(exeBID_i),
        .commitCnt_i(commitCnt_i), .restoreAck_i(restoreAck_i),
        .flush_o(flush_o), .flushAge_o(flushAge_o),
        .restoreReq_o(restoreReq_o), .restoreBID_o(restoreBID_o),
        .redirect_o(redirect_o), .redirectPC_o(redirectPC_o),
        .issueStall_o(issueStall_o)
`ifdef RECOVERY_STATS_EN
        , .mispredCnt_o(mispredCnt_o), .recoveryCyc_o(recoveryCyc_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of a recovery in progress.
    bit          m_busy;
    int          m_flush_left;
    bit          m_wait_ack;
    bit          m_redir;
    logic [31:0] m_pc;
    int          m_age;
    int          m_bid;
    logic [31:0] m_cnt;
    logic [31:0] m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_flush_left = 0; m_wait_ack = 0; m_redir = 0;
        m_pc = '0; m_age = 0; m_bid = 0; m_cnt = '0; m_cyc = '0;
    endtask

    // One clock of the recovery rules applied to the current inputs.
    task automatic model_step(input bit v, input bit mp, input logic [31:0] pc,
                              input int age, input int bid, input int cc, input bit ack);
        int  adj;
        bit  accept;
        adj = (m_age > cc) ? m_age - cc : 0;
        if (m_busy) m_cyc = m_cyc + 32'd1;
        accept = v && mp && (!m_busy || age < adj);
        if (accept) begin
            m_pc = pc; m_age = age; m_bid = bid; m_busy = 1;
            m_flush_left = FC; m_wait_ack = 0; m_redir = 0;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_age = adj;
            if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_wait_ack = 1;
            end else if (m_wait_ack) begin
                if (ack) begin m_wait_ack = 0; m_redir = 1; end
            end else if (m_redir) begin
                m_redir = 0; m_busy = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("flush_o",      32'(flush_o),      32'(m_flush_left > 0));
        chk("flushAge_o",   32'(flushAge_o),   32'(m_age));
        chk("restoreReq_o", 32'(restoreReq_o), 32'(m_wait_ack));
        chk("restoreBID_o", 32'(restoreBID_o), 32'(m_bid));
        chk("redirect_o",   32'(redirect_o),   32'(m_redir));
        chk("redirectPC_o", redirectPC_o,      m_pc);
        chk("issueStall_o", 32'(issueStall_o), 32'(m_busy));
`ifdef RECOVERY_STATS_EN
        chk("mispredCnt_o",  mispredCnt_o,  m_cnt);
        chk("recoveryCyc_o", recoveryCyc_o, m_cyc);
`endif
    endtask

    // Apply one cycle of inputs at the falling edge, check after the next one.
    task automatic cyc(input bit v, input bit mp, input logic [31:0] pc,
                       input int age, input int bid, input int cc, input bit ack);
        exeValid_i = v; exeMispredict_i = mp; exeNextPC_i = pc;
        exeAge_i = AGE_W'(age); exeBID_i = BID_W'(bid);
        commitCnt_i = 2'(cc); restoreAck_i = ack;
        model_step(v, mp, pc, age, bid, cc, ack);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic apply_reset();
        exeValid_i = 0; exeMispredict_i = 0; restoreAck_i = 0; commitCnt_i = '0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #3 check_all();
        @(negedge clk);
        reset = 1'b0;

        // 1: single recovery, ack on cycle 4
        apply_reset();
        cyc(1, 1, 32'h0040_0100, 5, 2, 0, 0);
        chk("s1_flush_c1", 32'(flush_o), 32'd1);
        idle(2);
        chk("s1_req_c3", 32'(restoreReq_o), 32'd1);
        chk("s1_bid_c3", 32'(restoreBID_o), 32'd2);
        idle(1);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        chk("s1_redir_c5", 32'(redirect_o), 32'd1);
        chk("s1_pc_c5", redirectPC_o, 32'h0040_0100);
        idle(1);
        chk("s1_idle_c6", 32'(issueStall_o), 32'd0);
`ifdef RECOVERY_STATS_EN
        chk("s1_mispred", mispredCnt_o, 32'd1);
        chk("s1_reccyc", recoveryCyc_o, 32'd5);
`endif

        // 2: older branch replaces the captured one and restarts the flush
        apply_reset();
        cyc(1, 1, 32'h0000_1000, 10, 1, 0, 0);
        idle(1);
        cyc(1, 1, 32'h0000_0500, 4, 3, 0, 0);
        chk("s2_flush_c3", 32'(flush_o), 32'd1);
        chk("s2_age", 32'(flushAge_o), 32'd4);
        idle(1);
        chk("s2_flush_c4", 32'(flush_o), 32'd1);
        idle(1);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        chk("s2_pc", redirectPC_o, 32'h0000_0500);
        chk("s2_redir", 32'(redirect_o), 32'd1);
`ifdef RECOVERY_STATS_EN
        chk("s2_mispred", mispredCnt_o, 32'd2);
`endif
        idle(2);

        // 3: younger branch during recovery is ignored
        apply_reset();
        cyc(1, 1, 32'h0000_2000, 4, 5, 0, 0);
        cyc(1, 1, 32'h0000_3000, 9, 6, 0, 0);
        idle(2);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        chk("s3_redir", 32'(redirect_o), 32'd1);
        chk("s3_pc", redirectPC_o, 32'h0000_2000);
        idle(2);

        // 4: commits age the stored branch; age 1 vs stored 0 is not older
        apply_reset();
        cyc(1, 1, 32'h0000_4000, 6, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 3, 0);
        cyc(0, 0, 32'h0, 0, 0, 3, 0);
        chk("s4_age0", 32'(flushAge_o), 32'd0);
        cyc(1, 1, 32'h0000_4444, 1, 7, 0, 0);
        chk("s4_ignored_pc", redirectPC_o, 32'h0000_4000);
        chk("s4_req", 32'(restoreReq_o), 32'd1);
        apply_reset();
        cyc(1, 1, 32'h0000_5000, 2, 1, 0, 0);
        cyc(1, 1, 32'h0000_5555, 0, 4, 0, 0);
        chk("s4_accept_pc", redirectPC_o, 32'h0000_5555);
        chk("s4_accept_bid", 32'(restoreBID_o), 32'd4);

        // 5: reset in the middle of a recovery
        apply_reset();
        cyc(1, 1, 32'h0000_6000, 3, 2, 0, 0);
        idle(1);
        chk("s5_flush_pre", 32'(flush_o), 32'd1);
        apply_reset();
        chk("s5_flush_post", 32'(flush_o), 32'd0);
        idle(8);

        // Randomized run, with rare resets
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                cyc(($urandom_range(0, 2) == 0), 1'($urandom), $urandom,
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
